// File: rtl/dvbc_srrc_interp.sv
// dvbc_srrc_interp: polyphase square-root-raised-cosine interpolating FIR
// for the DVB-C modulator. It takes one complex QAM symbol per handshake and
// emits OSR filtered complex samples per symbol. Coefficients load at run time.
// Ports: clk_i, rst_i (async, active-high); s_valid_i/s_ready_o/s_i_i/s_q_i
// form the symbol input; m_valid_o/m_ready_i/m_i_o/m_q_o form the sample
// output; coef_we_i/coef_addr_i/coef_data_i form the coefficient write port.
// Build option: define DVBC_SRRC_ROUND_EN to round half up before the shift.
// When it is not defined, the shift truncates (floor).
module dvbc_srrc_interp #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int OUT_W  = 12,
    parameter int TAPS   = 32,
    parameter int OSR    = 4,
    parameter int SHIFT  = 11
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic signed [DATA_W-1:0]  s_i_i,
    input  logic signed [DATA_W-1:0]  s_q_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic signed [OUT_W-1:0]   m_i_o,
    output logic signed [OUT_W-1:0]   m_q_o,
    input  logic                      coef_we_i,
    input  logic [$clog2(TAPS)-1:0]   coef_addr_i,
    input  logic signed [COEF_W-1:0]  coef_data_i
);

    localparam int TPP   = TAPS / OSR;
    localparam int AW    = $clog2(TAPS);
    localparam int PW    = $clog2(OSR);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TPP);
    // One guard bit so the rounding offset can never wrap the sum.
    localparam int SUM_W = ACC_W + 1;
    localparam logic [AW:0] TAPS_C = (AW + 1)'(TAPS);
`ifdef DVBC_SRRC_ROUND_EN
    // Evaluates to 2^(SHIFT-1), or to 0 when SHIFT is 0.
    localparam int RND_I = (1 << SHIFT) >> 1;
`else
    localparam int RND_I = 0;
`endif
    localparam logic signed [SUM_W-1:0] RND  = SUM_W'(RND_I);
    localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MINV = -MAXV - SUM_W'(1);

    typedef enum logic [1:0] {IDLE, CALC, WAIT} state_e;

    state_e                     state_q, state_d;
    logic [PW-1:0]              phase_q, phase_d;
    logic signed [DATA_W-1:0]   xi_q [TPP];
    logic signed [DATA_W-1:0]   xq_q [TPP];
    logic signed [COEF_W-1:0]   coef_q [TAPS];
    logic                       valid_q, valid_d;
    logic signed [OUT_W-1:0]    mi_q, mq_q;
    logic                       shift_en, res_ld;
    logic signed [SUM_W-1:0]    acc_i, acc_q, xe_i, xe_q, ce;
    logic signed [SUM_W-1:0]    sh_i, sh_q;
    logic [AW-1:0]              idx;

    function automatic logic signed [OUT_W-1:0] sat(
        input logic signed [SUM_W-1:0] v
    );
        if (v > MAXV) begin
            return {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (v < MINV) begin
            return {1'b1, {(OUT_W - 1){1'b0}}};
        end
        return OUT_W'(v);
    endfunction

    // Dot product of the delay line with the coefficients of the current phase.
    always_comb begin
        acc_i = '0;
        acc_q = '0;
        xe_i  = '0;
        xe_q  = '0;
        ce    = '0;
        idx   = '0;
        for (int k = 0; k < TPP; k++) begin
            idx   = AW'(k * OSR) + AW'(phase_q);
            ce    = SUM_W'(coef_q[idx]);
            xe_i  = SUM_W'(xi_q[k]);
            xe_q  = SUM_W'(xq_q[k]);
            acc_i = acc_i + xe_i * ce;
            acc_q = acc_q + xe_q * ce;
        end
        sh_i = (acc_i + RND) >>> SHIFT;
        sh_q = (acc_q + RND) >>> SHIFT;
    end

    assign s_ready_o = (state_q == IDLE) && !rst_i;
    assign m_valid_o = valid_q;
    assign m_i_o     = mi_q;
    assign m_q_o     = mq_q;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        valid_d  = valid_q;
        shift_en = 1'b0;
        res_ld   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid_i) begin
                    shift_en = 1'b1;
                    phase_d  = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                res_ld  = 1'b1;
                valid_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (m_ready_i) begin
                    valid_d = 1'b0;
                    if (phase_q == PW'(OSR - 1)) begin
                        state_d = IDLE;
                    end else begin
                        phase_d = phase_q + PW'(1);
                        state_d = CALC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            phase_q <= '0;
            valid_q <= 1'b0;
            mi_q    <= '0;
            mq_q    <= '0;
            for (int k = 0; k < TPP; k++) begin
                xi_q[k] <= '0;
                xq_q[k] <= '0;
            end
            for (int n = 0; n < TAPS; n++) begin
                coef_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            if (res_ld) begin
                mi_q <= sat(sh_i);
                mq_q <= sat(sh_q);
            end
            if (shift_en) begin
                for (int k = TPP - 1; k > 0; k--) begin
                    xi_q[k] <= xi_q[k-1];
                    xq_q[k] <= xq_q[k-1];
                end
                xi_q[0] <= s_i_i;
                xq_q[0] <= s_q_i;
            end
            if (coef_we_i && ({1'b0, coef_addr_i} < TAPS_C)) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
        end
    end

endmodule

// File: tb/tb_dvbc_srrc_interp.sv
// tb_dvbc_srrc_interp: randomized scoreboard bench for dvbc_srrc_interp.
// It uses an arithmetic reference model of the polyphase filter.
module tb_dvbc_srrc_interp;

    localparam int DW   = 8;
    localparam int CW   = 12;
    localparam int OW   = 12;
    localparam int TAPS = 32;
    localparam int OSR  = 4;
    localparam int SH   = 8;
    localparam int TPP  = TAPS / OSR;
    localparam int AW   = $clog2(TAPS);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic signed [DW-1:0]  s_i = '0;
    logic signed [DW-1:0]  s_q = '0;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic signed [OW-1:0]  m_i;
    logic signed [OW-1:0]  m_q;
    logic                  coef_we = 1'b0;
    logic [AW-1:0]         coef_addr = '0;
    logic signed [CW-1:0]  coef_data = '0;

    typedef struct {
        int i;
        int q;
    } samp_t;

    int    checks = 0;
    int    errors = 0;
    samp_t expq[$];
    int    hi[$];
    int    hq[$];
    int    cm[TAPS];
    int    rdy_mode = 0;
    int    mi, mq;
    samp_t e;

    dvbc_srrc_interp #(
        .DATA_W(DW), .COEF_W(CW), .OUT_W(OW),
        .TAPS(TAPS), .OSR(OSR), .SHIFT(SH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .s_i_i(s_i),
        .s_q_i(s_q),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .m_i_o(m_i),
        .m_q_o(m_q),
        .coef_we_i(coef_we),
        .coef_addr_i(coef_addr),
        .coef_data_i(coef_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout got 0 expected 1", name);
    endtask

    function automatic int model_out(input longint y);
        longint r;
`ifdef DVBC_SRRC_ROUND_EN
        if (SH > 0) y = y + (longint'(1) << (SH - 1));
`endif
        r = y >>> SH;
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return int'(r);
    endfunction

    // Newest symbol at index 0; each phase p uses taps k*OSR+p.
    function automatic void model_symbol(input int xi, input int xq);
        longint yi, yq;
        samp_t  s;
        hi.push_front(xi);
        hq.push_front(xq);
        if (hi.size() > TPP) void'(hi.pop_back());
        if (hq.size() > TPP) void'(hq.pop_back());
        for (int p = 0; p < OSR; p++) begin
            yi = 0;
            yq = 0;
            for (int k = 0; k < hi.size(); k++) begin
                yi += longint'(hi[k]) * longint'(cm[k*OSR+p]);
                yq += longint'(hq[k]) * longint'(cm[k*OSR+p]);
            end
            s.i = model_out(yi);
            s.q = model_out(yq);
            expq.push_back(s);
        end
    endfunction

    function automatic void model_reset();
        expq.delete();
        hi.delete();
        hq.delete();
        for (int n = 0; n < TAPS; n++) cm[n] = 0;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b0;
            1: m_ready = 1'b1;
            2: m_ready = ($urandom_range(3) != 0);
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            mi = m_i;
            mq = m_q;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample got %0d,%0d expected none", mi, mq);
            end else begin
                e = expq.pop_front();
                if (mi != e.i || mq != e.q) begin
                    errors++;
                    $display("FAIL sample got %0d,%0d expected %0d,%0d", mi, mq, e.i, e.q);
                end
            end
        end
    end

    task automatic wcoef(input int a, input int v);
        @(posedge clk);
        #1;
        coef_we   = 1'b1;
        coef_addr = a[AW-1:0];
        coef_data = v[CW-1:0];
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        cm[a] = v;
    endtask

    task automatic send(input int xi, input int xq);
        int n = 0;
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_i = xi[DW-1:0];
        s_q = xq[DW-1:0];
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 500) begin
                timeout("send");
                s_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_symbol(xi, xq);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(negedge clk);
            if (expq.size() == 0 && s_ready && !m_valid) break;
            n++;
            if (n > 3000) begin
                timeout("drain");
                return;
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (m_valid) break;
            n++;
            if (n > 200) begin
                timeout(name);
                return;
            end
        end
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int hold_i, hold_q, r;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_i", int'(m_i), 0);
        chk("rst_m_q", int'(m_q), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", int'(s_ready), 1);

        // Impulse through tap 0, plus first-sample latency.
        rdy_mode = 1;
        wcoef(0, 256);
        send(5, -3);
        @(negedge clk);
        chk("latency_calc_cycle", int'(m_valid), 0);
        @(negedge clk);
        chk("latency_valid", int'(m_valid), 1);
        send(7, 1);
        drain();

        // Polyphase ordering from a cleared line.
        rst_pulse();
        for (int n = 0; n < TAPS; n++) wcoef(n, n << 6);
        send(64, 0);
        drain();

        // Saturation on both rails.
        rst_pulse();
        for (int k = 0; k < TPP; k++) wcoef(k * OSR, 2047);
        for (int n = 0; n < 8; n++) send(127, -128);
        drain();

        // Rounding versus truncation of negative and positive halves.
        rst_pulse();
        wcoef(0, 128);
        send(3, 0);
        send(-3, 0);
        drain();

        // Backpressure; a symbol offered during WAIT must be ignored.
        wcoef(4, 256);
        rdy_mode = 0;
        send(11, -6);
        wait_valid("bp_valid");
        hold_i = m_i;
        hold_q = m_q;
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_i = 8'sd99;
        s_q = -8'sd77;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid_hold", int'(m_valid), 1);
            chk("bp_i_hold", int'(m_i), hold_i);
            chk("bp_q_hold", int'(m_q), hold_q);
            chk("bp_s_ready", int'(s_ready), 0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        rdy_mode = 1;
        drain();
        chk("bp_s_ready_back", int'(s_ready), 1);
        send(2, 2);
        drain();

        // Reset while waiting on phase 2.
        rdy_mode = 3;
        m_ready = 1'b0;
        send(20, 10);
        for (int p = 0; p < 2; p++) begin
            wait_valid("rst_phase_valid");
            @(posedge clk);
            #1;
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            m_ready = 1'b0;
        end
        wait_valid("rst_phase2_valid");
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_m_valid", int'(m_valid), 0);
        chk("midrst_m_i", int'(m_i), 0);
        chk("midrst_m_q", int'(m_q), 0);
        chk("midrst_s_ready", int'(s_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", int'(s_ready), 1);
        rdy_mode = 1;
        wcoef(0, 256);
        send(9, -4);
        drain();

        // Random coefficients, symbols and downstream stalls.
        rdy_mode = 2;
        for (int n = 0; n < TAPS; n++) begin
            r = int'($urandom_range(4095)) - 2048;
            wcoef(n, r);
        end
        for (int n = 0; n < 40; n++) begin
            send(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
        end
        drain();
        chk("queue_empty", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
